// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: turns ASCII drive-command bytes from the UART receiver
// into the one-hot direction word for the dual-motor driver. Inserts a STOP
// dwell on forward/backward reversal and forces STOP when the link goes quiet.
module motor_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 62_500_000,
  parameter int DEAD_CYCLES    = 1_250_000
) (
  input  logic       clk_125mhz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] direction,
  output logic       cmd_err,
  output logic       timed_out,
  output logic       reversing
);

  localparam int WD_W   = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DEAD_W = ($clog2(DEAD_CYCLES) > 0) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [WD_W-1:0]   WD_ZERO   = WD_W'(0);
  localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_ZERO = DEAD_W'(0);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [4:0] DIR_NONE  = 5'b00000;
  localparam logic [4:0] DIR_FWD   = 5'b00001;
  localparam logic [4:0] DIR_BWD   = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_RIGHT = 5'b01000;
  localparam logic [4:0] DIR_STOP  = 5'b10000;

  // Map a received byte to its direction code; DIR_NONE marks an illegal byte.
  function automatic logic [4:0] decode_cmd(input logic [7:0] b);
    logic [4:0] d;
    case (b)
      8'h46, 8'h66: d = DIR_FWD;
      8'h42, 8'h62: d = DIR_BWD;
      8'h4C, 8'h6C: d = DIR_LEFT;
      8'h52, 8'h72: d = DIR_RIGHT;
      8'h53, 8'h73: d = DIR_STOP;
      default:      d = DIR_NONE;
    endcase
    return d;
  endfunction

  // True when moving from cur to nxt flips the drive between forward and backward.
  function automatic logic is_reversal(input logic [4:0] cur, input logic [4:0] nxt);
    return ((cur == DIR_FWD) && (nxt == DIR_BWD)) ||
           ((cur == DIR_BWD) && (nxt == DIR_FWD));
  endfunction

  logic [1:0]        state_r, state_s;
  logic [4:0]        dir_r, dir_s;
  logic [4:0]        pending_r, pending_s;
  logic [WD_W-1:0]   wd_cnt_r, wd_cnt_s;
  logic [DEAD_W-1:0] dead_cnt_r, dead_cnt_s;
  logic              cmd_err_r, cmd_err_s;
  logic              timed_out_r, timed_out_s;
  logic              reversing_r, reversing_s;

  logic [4:0]        cmd_s;
  logic              legal_s;
  logic              stop_cmd_s;
  logic              expire_s;

  // Decode the incoming strobe and compute the next state of every register.
  always_comb begin
    cmd_s       = decode_cmd(rx_data);
    legal_s     = rx_valid && (cmd_s != DIR_NONE);
    stop_cmd_s  = (cmd_s == DIR_STOP);
    expire_s    = (wd_cnt_r == WD_LAST) && !legal_s;

    state_s     = state_r;
    dir_s       = dir_r;
    pending_s   = pending_r;
    wd_cnt_s    = wd_cnt_r;
    dead_cnt_s  = dead_cnt_r;
    reversing_s = reversing_r;
    cmd_err_s   = rx_valid && (cmd_s == DIR_NONE);
    timed_out_s = legal_s ? 1'b0 : timed_out_r;

    case (state_r)
      ST_IDLE: begin
        wd_cnt_s    = WD_ZERO;
        dead_cnt_s  = DEAD_ZERO;
        pending_s   = DIR_STOP;
        reversing_s = 1'b0;
        if (legal_s && !stop_cmd_s) begin
          state_s = ST_RUN;
          dir_s   = cmd_s;
        end else begin
          dir_s   = DIR_STOP;
        end
      end

      ST_RUN: begin
        if (legal_s) begin
          wd_cnt_s = WD_ZERO;
          if (stop_cmd_s) begin
            state_s = ST_IDLE;
            dir_s   = DIR_STOP;
          end else if (is_reversal(dir_r, cmd_s)) begin
            state_s     = ST_DEAD;
            dir_s       = DIR_STOP;
            pending_s   = cmd_s;
            dead_cnt_s  = DEAD_ZERO;
            reversing_s = 1'b1;
          end else begin
            dir_s = cmd_s;
          end
        end else if (expire_s) begin
          state_s     = ST_IDLE;
          dir_s       = DIR_STOP;
          pending_s   = DIR_STOP;
          wd_cnt_s    = WD_ZERO;
          timed_out_s = 1'b1;
        end else begin
          wd_cnt_s = wd_cnt_r + WD_ONE;
        end
      end

      ST_DEAD: begin
        dir_s = DIR_STOP;
        if (legal_s && stop_cmd_s) begin
          state_s     = ST_IDLE;
          pending_s   = DIR_STOP;
          wd_cnt_s    = WD_ZERO;
          dead_cnt_s  = DEAD_ZERO;
          reversing_s = 1'b0;
        end else if (expire_s) begin
          state_s     = ST_IDLE;
          pending_s   = DIR_STOP;
          wd_cnt_s    = WD_ZERO;
          dead_cnt_s  = DEAD_ZERO;
          reversing_s = 1'b0;
          timed_out_s = 1'b1;
        end else begin
          // A motion command only retargets the dwell; it never restarts it.
          if (legal_s) begin
            pending_s = cmd_s;
            wd_cnt_s  = WD_ZERO;
          end else begin
            wd_cnt_s  = wd_cnt_r + WD_ONE;
          end
          if (dead_cnt_r == DEAD_LAST) begin
            state_s     = ST_RUN;
            dir_s       = pending_s;
            dead_cnt_s  = DEAD_ZERO;
            reversing_s = 1'b0;
          end else begin
            dead_cnt_s  = dead_cnt_r + DEAD_ONE;
          end
        end
      end

      default: begin
        state_s     = ST_IDLE;
        dir_s       = DIR_STOP;
        pending_s   = DIR_STOP;
        wd_cnt_s    = WD_ZERO;
        dead_cnt_s  = DEAD_ZERO;
        reversing_s = 1'b0;
      end
    endcase
  end

  // Register state and outputs; reset returns to IDLE with the motors stopped.
  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      dir_r       <= DIR_STOP;
      pending_r   <= DIR_STOP;
      wd_cnt_r    <= WD_ZERO;
      dead_cnt_r  <= DEAD_ZERO;
      cmd_err_r   <= 1'b0;
      timed_out_r <= 1'b0;
      reversing_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      dir_r       <= dir_s;
      pending_r   <= pending_s;
      wd_cnt_r    <= wd_cnt_s;
      dead_cnt_r  <= dead_cnt_s;
      cmd_err_r   <= cmd_err_s;
      timed_out_r <= timed_out_s;
      reversing_r <= reversing_s;
    end
  end

  assign direction = dir_r;
  assign cmd_err   = cmd_err_r;
  assign timed_out = timed_out_r;
  assign reversing = reversing_r;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed walk through the main scenarios,
// then randomized byte traffic compared cycle by cycle with a reference model.
module tb_motor_cmd_sequencer;

  localparam int TO   = 100;
  localparam int DEAD = 10;

  logic       clk_125mhz;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] direction;
  logic       cmd_err;
  logic       timed_out;
  logic       reversing;

  motor_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .DEAD_CYCLES(DEAD)) dut (
    .clk_125mhz(clk_125mhz),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .direction (direction),
    .cmd_err   (cmd_err),
    .timed_out (timed_out),
    .reversing (reversing)
  );

  initial clk_125mhz = 1'b0;
  always #5 clk_125mhz = ~clk_125mhz;

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: mode 0 idle, 1 running, 2 reversal dwell.
  int         m_mode;
  logic [4:0] m_dir;
  logic [4:0] m_pend;
  int         m_quiet;
  int         m_age;
  logic       m_err;
  logic       m_to;
  logic       m_rev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Case-insensitive command lookup; 0 means not a command.
  function automatic logic [4:0] ref_decode(input logic [7:0] b);
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    if (u == 8'h46) return 5'b00001;
    if (u == 8'h42) return 5'b00010;
    if (u == 8'h4C) return 5'b00100;
    if (u == 8'h52) return 5'b01000;
    if (u == 8'h53) return 5'b10000;
    return 5'b00000;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    logic [4:0] c;
    logic legal;
    if (r) begin
      m_mode = 0; m_dir = 5'b10000; m_pend = 5'b10000; m_quiet = 0; m_age = 0;
      m_err = 1'b0; m_to = 1'b0; m_rev = 1'b0;
      return;
    end
    c = v ? ref_decode(d) : 5'b00000;
    legal = (c != 5'b00000);
    m_err = v && !legal;
    if (legal) m_to = 1'b0;
    if (m_mode != 0 && !legal && m_quiet == TO - 1) begin
      m_mode = 0; m_dir = 5'b10000; m_to = 1'b1; m_rev = 1'b0; m_quiet = 0;
    end else if (m_mode == 0) begin
      if (legal && c != 5'b10000) begin m_mode = 1; m_dir = c; m_quiet = 0; end
    end else if (m_mode == 1) begin
      if (!legal) m_quiet++;
      else begin
        m_quiet = 0;
        if (c == 5'b10000) begin m_mode = 0; m_dir = c; end
        else if ((m_dir | c) == 5'b00011) begin
          m_mode = 2; m_age = 0; m_pend = c; m_dir = 5'b10000; m_rev = 1'b1;
        end else m_dir = c;
      end
    end else begin
      if (legal && c == 5'b10000) begin
        m_mode = 0; m_rev = 1'b0; m_quiet = 0;
      end else begin
        if (legal) begin m_pend = c; m_quiet = 0; end
        else m_quiet++;
        if (m_age == DEAD - 1) begin m_mode = 1; m_dir = m_pend; m_rev = 1'b0; end
        else m_age++;
      end
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare at the falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    rx_valid = v; rx_data = d; reset = r;
    @(posedge clk_125mhz);
    model_step(v, d, r);
    @(negedge clk_125mhz);
    check("direction", direction, m_dir);
    check("cmd_err", cmd_err, m_err);
    check("timed_out", timed_out, m_to);
    check("reversing", reversing, m_rev);
    check("onehot", $countones(direction), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] cmd_tab [0:10];
  int silence;

  initial begin
    cmd_tab[0] = 8'h46; cmd_tab[1] = 8'h66; cmd_tab[2]  = 8'h42; cmd_tab[3] = 8'h62;
    cmd_tab[4] = 8'h4C; cmd_tab[5] = 8'h6C; cmd_tab[6]  = 8'h52; cmd_tab[7] = 8'h72;
    cmd_tab[8] = 8'h53; cmd_tab[9] = 8'h73; cmd_tab[10] = 8'h58;

    // Reset state.
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h46, 1'b1);
    check("rst_dir", direction, 5'b10000);
    check("rst_flags", {cmd_err, timed_out, reversing}, 3'b000);

    // Basic decode and one-cycle latency.
    idle(3);
    cycle(1'b1, 8'h46, 1'b0); check("tp_F", direction, 5'b00001);
    idle(2);
    cycle(1'b1, 8'h6C, 1'b0); check("tp_l", direction, 5'b00100);
    cycle(1'b1, 8'h53, 1'b0); check("tp_S", direction, 5'b10000);

    // Forward to backward reversal inserts DEAD cycles of STOP.
    cycle(1'b1, 8'h46, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    check("dead_first", {reversing, direction}, {1'b1, 5'b10000});
    idle(9);
    check("dead_last", {reversing, direction}, {1'b1, 5'b10000});
    idle(1);
    check("dead_exit", {reversing, direction}, {1'b0, 5'b00010});

    // Retarget mid-dwell: exit time unchanged, new pending applied.
    cycle(1'b1, 8'h46, 1'b0);
    idle(3);
    cycle(1'b1, 8'h42, 1'b0);
    idle(5);
    check("retarget_hold", direction, 5'b10000);
    idle(1);
    check("retarget_exit", {reversing, direction}, {1'b0, 5'b00010});

    // STOP mid-dwell aborts immediately.
    cycle(1'b1, 8'h46, 1'b0);
    idle(3);
    cycle(1'b1, 8'h53, 1'b0);
    check("dead_abort", {reversing, direction}, {1'b0, 5'b10000});

    // Watchdog expiry after silence, then recovery.
    cycle(1'b1, 8'h52, 1'b0);
    idle(99);
    check("wd_before", {timed_out, direction}, {1'b0, 5'b01000});
    idle(1);
    check("wd_expired", {timed_out, direction}, {1'b1, 5'b10000});
    cycle(1'b1, 8'h66, 1'b0);
    check("wd_recover", {timed_out, direction}, {1'b0, 5'b00001});

    // Legal byte on the expiry cycle wins.
    idle(99);
    cycle(1'b1, 8'h4C, 1'b0);
    check("wd_race", {timed_out, direction}, {1'b0, 5'b00100});

    // Illegal byte: one-cycle error pulse, watchdog not refreshed.
    idle(19);
    cycle(1'b1, 8'h58, 1'b0);
    check("err_pulse", {cmd_err, direction}, {1'b1, 5'b00100});
    idle(1);
    check("err_clear", cmd_err, 1'b0);
    idle(78);
    check("err_wd_before", {timed_out, direction}, {1'b0, 5'b00100});
    idle(1);
    check("err_wd_expired", {timed_out, direction}, {1'b1, 5'b10000});

    // Reset during DEAD with a byte present.
    cycle(1'b1, 8'h46, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    idle(2);
    cycle(1'b1, 8'h46, 1'b1);
    check("rst_dead", {direction, reversing, timed_out, cmd_err}, {5'b10000, 3'b000});

    // Randomized traffic with silences and occasional resets.
    silence = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) cycle(1'b0, 8'h00, 1'b1);
      else if (silence > 0) begin
        silence--;
        cycle(1'b0, 8'h00, 1'b0);
      end else begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) silence = $urandom_range(80, 120);
        if (r < 60) cycle(1'b0, 8'h00, 1'b0);
        else if (r < 95) cycle(1'b1, cmd_tab[$urandom_range(0, 10)], 1'b0);
        else cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Upstream feeder of the dual-motor driver stage.
- Converts ASCII drive-command bytes, delivered as a byte-valid strobe from the UART receiver, into the 5-bit one-hot direction word the driver consumes.
- Adds two safety features: a dead-time STOP on forward/backward reversal, and a command watchdog that forces STOP when the link goes silent.

Parameters:
- TIMEOUT_CYCLES, 62_500_000: clock cycles without a valid command before forced STOP (0.5 s at 125 MHz).
- DEAD_CYCLES, 1_250_000: STOP dwell inserted on FORWARD<->BACKWARD reversal (10 ms at 125 MHz).

Ports:
- clk_125mhz  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received command byte; sampled only when rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per byte.
- direction  output  5  registered one-hot: FORWARD 00001, BACKWARD 00010, LEFT 00100, RIGHT 01000, STOP 10000.
- cmd_err  output  1  one-cycle pulse; the byte sampled the previous cycle was not a legal command.
- timed_out  output  1  level; set on watchdog expiry, cleared by the next legal command.
- reversing  output  1  level; high while in DEAD.

Behaviour:
- Reset (synchronous, active-high) forces:
  - direction=10000 (STOP), cmd_err=0, timed_out=0, reversing=0.
  - State IDLE; watchdog and dead counters = 0; pending = STOP.
- Decode, case-insensitive:
  - 'F'/'f' (0x46/0x66) -> FORWARD; 'B'/'b' (0x42/0x62) -> BACKWARD.
  - 'L'/'l' (0x4C/0x6C) -> LEFT; 'R'/'r' (0x52/0x72) -> RIGHT.
  - 'S'/'s' (0x53/0x73) -> STOP.
  - Any other byte: cmd_err=1 on the next cycle. State, direction and watchdog are unchanged.
- Latency: legal byte with rx_valid in cycle N -> direction updated at edge N+1, visible in cycle N+1.
- Every legal command clears the watchdog counter and timed_out.
- States:
  - IDLE: direction=STOP, watchdog halted.
    - Motion command -> RUN, direction=cmd.
    - STOP command -> stays IDLE.
  - RUN: watchdog increments each cycle.
    - Same or non-reversing motion command -> direction=cmd, stay RUN.
    - STOP command -> IDLE.
    - FORWARD->BACKWARD or BACKWARD->FORWARD command -> DEAD: direction=STOP, pending=cmd, dead counter=0, reversing=1.
  - DEAD: direction held STOP; dead counter and watchdog both increment.
    - Motion command -> replaces pending; dead counter is NOT restarted.
    - STOP command -> IDLE immediately, pending discarded, reversing=0.
    - When dead counter reaches DEAD_CYCLES-1 -> RUN next cycle, direction=pending, reversing=0.
- Watchdog expiry: counter reaches TIMEOUT_CYCLES-1 in RUN or DEAD with no legal command that cycle.
  - Next cycle: IDLE, direction=STOP, timed_out=1, pending discarded.
- Simultaneous events:
  - Legal command in the same cycle as watchdog expiry: the command wins, no timeout.
  - Legal motion command on the final DEAD cycle: it becomes pending and is applied next cycle.
  - Illegal byte never extends DEAD and never refreshes the watchdog.
- Reset asserted mid-DEAD or mid-RUN: next cycle equals the post-reset state, regardless of rx_valid.
- direction is always exactly one-hot; no other code is ever driven.
- Counters are sized by $clog2 of their parameter; no wrap-around is reachable because expiry resets them.

Test Plan (TIMEOUT_CYCLES=100, DEAD_CYCLES=10 unless noted):
- Reset, then 'F' strobe at cycle 5 -> direction=00001 at cycle 6; 'l' at cycle 8 -> 00100 at cycle 9; 'S' -> 10000 one cycle later.
- In RUN/FORWARD, send 'B' at cycle N -> direction=10000 and reversing=1 during cycles N+1..N+10; direction=00010 and reversing=0 from cycle N+11.
- During DEAD send 'F' at dead count 3 -> still exits at N+11, but with direction=00001. Separately, 'S' at dead count 3 -> direction=STOP with immediate exit to IDLE and reversing=0.
- 'R', then silence -> direction=01000 for 100 cycles, then 10000 with timed_out=1. A later 'f' clears timed_out and gives direction=00001. Legal byte on the expiry cycle -> no timeout.
- Byte 0x58 ('X') in RUN/LEFT -> cmd_err pulse of exactly 1 cycle, direction stays 00100, and the watchdog still expires 100 cycles after the last legal byte.
- Assert reset mid-DEAD with rx_valid=1 -> next cycle direction=10000 with reversing, timed_out and cmd_err all 0. The bench checks one-hot on direction every cycle.
